// File: rtl/mii_tx_sched.sv
// Two-requester round-robin MII transmit scheduler: preamble/SFD, byte-to-nibble serialiser, IFG.
// Optional MII_TX_SCHED_TX_ER_EN: drive tx_er on bad frames and on underrun.
module mii_tx_sched #(
  parameter int PRE_BYTES   = 7,
  parameter int IFG_NIBBLES = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic       s0_tlast,
  input  logic       s0_tuser,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic       s1_tlast,
  input  logic       s1_tuser,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       mii_tx_er,
  output logic [1:0] grant,
  output logic       underrun
);

`ifdef MII_TX_SCHED_TX_ER_EN
  localparam logic ER_EN = 1'b1;
`else
  localparam logic ER_EN = 1'b0;
`endif

  localparam int PRE_LEN = 2 * PRE_BYTES + 2;
  localparam int CNT_MAX = (PRE_LEN > IFG_NIBBLES) ? PRE_LEN : IFG_NIBBLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PRE_SFD  = CW'(PRE_LEN - 2);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_NIBBLES - 2);

  typedef enum logic [2:0] {IDLE, PRE, DATA_LO, DATA_HI, DRAIN, IFG} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          rr_q, rr_d;
  logic [3:0]    hold_hi_q, hold_hi_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_user_q, hold_user_d;
  logic [3:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_er_q, tx_er_d;

  logic       ready, under, take_byte;
  logic       in_valid, in_last, in_user;
  logic [7:0] in_data;

  // The owner's stream is selected by the registered grant.
  assign in_valid = grant_q[1] ? s1_tvalid : s0_tvalid;
  assign in_last  = grant_q[1] ? s1_tlast  : s0_tlast;
  assign in_user  = grant_q[1] ? s1_tuser  : s0_tuser;
  assign in_data  = grant_q[1] ? s1_tdata  : s0_tdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    hold_hi_d   = hold_hi_q;
    hold_last_d = hold_last_q;
    hold_user_d = hold_user_q;
    txd_d       = 4'h0;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    ready       = 1'b0;
    under       = 1'b0;
    take_byte   = 1'b0;
    // Output registers are loaded with what the next state must show.
    case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          if (s0_tvalid && (!s1_tvalid || rr_q)) begin
            grant_d = 2'b01;
            rr_d    = 1'b0;
          end else begin
            grant_d = 2'b10;
            rr_d    = 1'b1;
          end
          state_d = PRE;
          cnt_d   = '0;
          tx_en_d = 1'b1;
          txd_d   = 4'h5;
        end
      end
      PRE: begin
        if (cnt_q != PRE_LAST) begin
          cnt_d   = cnt_q + CW'(1);
          tx_en_d = 1'b1;
          txd_d   = (cnt_q == PRE_SFD) ? 4'hD : 4'h5;
        end else begin
          ready     = 1'b1;
          take_byte = 1'b1;
        end
      end
      DATA_LO: begin
        state_d = DATA_HI;
        tx_en_d = 1'b1;
        txd_d   = hold_hi_q;
        tx_er_d = ER_EN & hold_last_q & hold_user_q;
      end
      DATA_HI: begin
        if (hold_last_q) begin
          state_d = IFG;
          cnt_d   = '0;
          grant_d = 2'b00;
        end else begin
          ready     = 1'b1;
          take_byte = 1'b1;
        end
      end
      DRAIN: begin
        ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = IFG;
          cnt_d   = '0;
          grant_d = 2'b00;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A required byte either arrives or the frame is cut short.
    if (take_byte) begin
      if (in_valid) begin
        hold_hi_d   = in_data[7:4];
        hold_last_d = in_last;
        hold_user_d = in_user;
        state_d     = DATA_LO;
        tx_en_d     = 1'b1;
        txd_d       = in_data[3:0];
        tx_er_d     = ER_EN & in_last & in_user;
      end else begin
        under   = 1'b1;
        state_d = DRAIN;
        tx_en_d = ER_EN;
        tx_er_d = ER_EN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 2'b00;
      rr_q        <= 1'b1;
      hold_hi_q   <= 4'h0;
      hold_last_q <= 1'b0;
      hold_user_q <= 1'b0;
      txd_q       <= 4'h0;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      hold_hi_q   <= hold_hi_d;
      hold_last_q <= hold_last_d;
      hold_user_q <= hold_user_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
    end
  end

  assign s0_tready = ready & grant_q[0];
  assign s1_tready = ready & grant_q[1];
  assign mii_txd   = txd_q;
  assign mii_tx_en = tx_en_q;
  assign mii_tx_er = tx_er_q;
  assign grant     = grant_q;
  assign underrun  = under;

endmodule

// File: doc/mii_tx_sched.md
Name: mii_tx_sched

Overview:
- Two-requester transmit scheduler driving one shared MII PHY transmit interface (txd[3:0], tx_en, tx_er on the PHY tx clock).
- Round-robin arbitrates between two byte-wide AXI-stream frame sources.
- Generates preamble and SFD, serialises bytes to nibbles low nibble first, and enforces the inter-frame gap.
- Sits between the MAC frame queues and the MII PHY pins; runs entirely in the tx clock domain.

Parameters:
- PRE_BYTES, 7, preamble bytes of 0x55 sent before the SFD byte 0xD5.
- IFG_NIBBLES, 24, minimum tx_en-low cycles between frames (12 byte times).

Ports:
- clk  in  1  MII transmit clock; one nibble per cycle.
- rst  in  1  reset; asynchronous, active-high.
- s0_tdata / s1_tdata  in  8  frame byte from requester 0 / 1.
- s0_tvalid / s1_tvalid  in  1  byte valid.
- s0_tready / s1_tready  out  1  byte accepted when tvalid && tready.
- s0_tlast / s1_tlast  in  1  last byte of frame.
- s0_tuser / s1_tuser  in  1  bad-frame flag, sampled with tlast.
- mii_txd  out  4  registered nibble to PHY.
- mii_tx_en  out  1  registered transmit enable.
- mii_tx_er  out  1  registered transmit error.
- grant  out  2  one-hot owner of the current frame; 0 when idle.
- underrun  out  1  one-cycle pulse when the granted source stalls mid-frame.

Behaviour:
- Reset (async, any state): mii_txd=0, mii_tx_en=0, mii_tx_er=0, grant=0, underrun=0, s*_tready=0, state=IDLE, rr pointer=1 so requester 0 wins the first tie.
- States: IDLE, PRE, DATA_LO, DATA_HI, DRAIN, IFG.
- IDLE:
  - tx_en=0.
  - If exactly one tvalid is high, grant that requester.
  - If both are high, grant the requester other than the rr pointer; the pointer then updates to the winner.
  - The grant registers this cycle; go to PRE.
- PRE:
  - 2*PRE_BYTES+2 cycles with tx_en=1. Nibbles: 0x5 for 2*PRE_BYTES+1 cycles, then 0xD.
  - The first preamble nibble appears at the output 1 cycle after the IDLE grant cycle.
  - tready of the granted port is high in the final PRE cycle only.
- Byte handshake:
  - A byte accepted in cycle t is captured into a holding register.
  - DATA_LO (t+1) outputs byte[3:0]; DATA_HI (t+2) outputs byte[7:4].
  - tready is high during DATA_HI unless the held byte had tlast, giving a sustained 1 byte per 2 cycles.
- After the DATA_HI of a tlast byte: tx_en=0, grant=0, go to IFG.
- IFG:
  - Hold for IFG_NIBBLES-1 cycles, then go to IDLE.
  - tx_en stays low for exactly IFG_NIBBLES cycles when frames are back-to-back.
- Underrun: tready high and tvalid low in a required cycle.
  - underrun pulses for 1 cycle and the frame ends: tx_en drops in the next cycle.
  - Go to DRAIN: granted tready=1, discard bytes until tlast is accepted, then go to IFG with the IFG counter starting at that point.
  - If the stall occurs in the final PRE cycle, no data is sent; the truncated preamble still ends.
- The non-granted requester sees tready=0 throughout.
- Reset during a frame: tx_en deasserts asynchronously. Source-side frame cleanup is the source's responsibility.

Optional Feature:
- Macro: MII_TX_SCHED_TX_ER_EN.
- Defined:
  - mii_tx_er=1 on both nibbles of a tlast byte whose tuser=1.
  - On underrun, one extra cycle is sent with tx_en=1, tx_er=1, txd=0 before tx_en drops.
- Undefined: mii_tx_er is constant 0; tuser is ignored; underrun only truncates the frame.

Test Plan:
- s0 sends a 3-byte frame {0x12,0x34,0x56}, s1 idle → tx_en high for 22 cycles. txd sequence: 15x 0x5, 0xD, 2,1,4,3,6,5. grant=01 throughout.
- s0 and s1 both valid out of reset, 2-byte frames each → s0 frame first, then exactly 24 tx_en-low cycles, then s1 frame. Next tie goes to s0.
- s1 frame sent back-to-back with s0 holding a frame pending → grant alternates 10, 01, 10 across three consecutive ties.
- s0 deasserts tvalid after byte 2 of 5 → underrun pulses once, tx_en drops the next cycle. Remaining bytes are drained until tlast, then IFG of 24 cycles.
- Feature defined: last byte 0xAB with tuser=1 → txd B then A with tx_er=1 on both cycles. Feature undefined: tx_er stays 0.
- rst asserted mid-DATA_LO → all outputs 0 in the same cycle. After release, the first tie grants s0.
